cpu_clk_ctrl: RTL and testbench

Run/step/breakpoint controller for the CPU clock enable. Replaces free-running switch-selected CPU clock division with a sequenced enable. Modes:
- **Free-run** at a switch-selected rate.
- **Single-step** from a debounced key press.
- **Halt** on a PC breakpoint.

Sits between the board inputs (sw, key1) and the pipelined CPU. The CPU advances one cycle per `cpu_clk_en` pulse.

---
 rtl/cpu_clk_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl - run / single-step / breakpoint controller for the CPU clock enable.
//
// The CPU advances one cycle for every cpu_clk_en pulse. Pulses come from a
// switch-selected rate divider while running, or from a debounced key press
// while halted or stopped at a breakpoint.
//
// Ports
//   clk          system clock, the only clock
//   rst          synchronous reset, active-high
//   sw[15:0]     sw[0] run enable, sw[1] breakpoint enable, sw[15:4] rate select
//   key1         asynchronous step/resume button, active-high
//   pc_in[31:0]  current CPU PC
//   bp_addr[31:0] breakpoint address
//   cpu_clk_en   registered one-cycle enable pulse to the CPU
//   state_o[1:0] HALT=00, RUN=01, STEP=10, BREAK=11
//   pulse_count  number of cpu_clk_en pulses issued, wraps
//   LED_clk[2:0] [0] RUN, [1] HALT, [2] BREAK
//
// Build option
//   CLK_CTRL_BP_EN  when defined, the PC breakpoint compare and BREAK state are
//                   present; otherwise bp_addr and sw[1] are ignored.
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | clock stopped, waiting for run enable or a step key press
// RUN   | free-running, one pulse per divider tick
// STEP  | single pulse this cycle, then back to RUN or HALT
// BREAK | stopped on a PC breakpoint, key press steps past it

module cpu_clk_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DIV_WIDTH = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        key1,
    input  logic [31:0] pc_in,
    input  logic [31:0] bp_addr,
    output logic        cpu_clk_en,
    output logic [1:0]  state_o,
    output logic [31:0] pulse_count,
    output logic [2:0]  LED_clk
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_run_pulse;
    logic                 r_clk_en;
    logic [31:0]          r_pulse_count;

    logic                 r_key_s1;
    logic                 r_key_s2;
    logic [1:0]           r_sync_fill;
    logic [DBW-1:0]       r_db_cnt;
    logic                 r_key_lvl;
    logic                 r_key_lvl_d;
    logic                 r_key_armed;
    logic                 r_key_press;

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_div_mask;
    logic [4:0]           w_rate_k;
    logic                 w_tick;
    logic                 w_bp_hit;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Key path: 2-FF synchronizer, stable-time debounce, rising-edge pulse.
    // r_sync_fill marks when r_key_s2 holds a post-reset sample of key1;
    // a press is only accepted once the key has been seen released after
    // reset, so a key held through reset never produces a step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1    <= 1'b0;
            r_key_s2    <= 1'b0;
            r_sync_fill <= 2'b00;
            r_db_cnt    <= '0;
            r_key_lvl   <= 1'b0;
            r_key_lvl_d <= 1'b0;
            r_key_armed <= 1'b0;
            r_key_press <= 1'b0;
        end else begin
            r_key_s1    <= key1;
            r_key_s2    <= r_key_s1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            if (r_key_s2 != r_key_lvl) begin
                if (r_db_cnt == DBW'(DB_CYCLES - 1)) begin
                    r_key_lvl <= r_key_s2;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
            r_key_lvl_d <= r_key_lvl;
            if (r_sync_fill[1] && !r_key_s2 && !r_key_lvl) begin
                r_key_armed <= 1'b1;
            end
            r_key_press <= r_key_lvl && !r_key_lvl_d && r_key_armed;
        end
    end

    // ------------------------------------------------------------------
    // Rate select: sw[4] has highest priority (k=2), then sw[5]..sw[15]
    // (k=15..25), k=26 with nothing set. Tick when divider bits [k-1:0]
    // are all ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_rate_k = 5'd26;
        for (int i = 15; i >= 5; i--) begin
            if (sw[i]) begin
                w_rate_k = 5'(i + 10);
            end
        end
        if (sw[4]) begin
            w_rate_k = 5'd2;
        end
    end

    always_comb begin
        w_div_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            w_div_mask[i] = (i < int'(w_rate_k));
        end
    end

    assign w_tick = ((r_div & w_div_mask) == w_div_mask);

    // Divider only advances in RUN; a rate change re-masks the running count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_state == ST_RUN) begin
            r_div <= r_div + DIV_WIDTH'(1);
        end else begin
            r_div <= '0;
        end
    end

`ifdef CLK_CTRL_BP_EN
    assign w_bp_hit = sw[1] && (pc_in == bp_addr);
    assign w_unused = ^sw[3:2];
`else
    assign w_bp_hit = 1'b0;
    assign w_unused = ^{sw[3:1], pc_in, bp_addr};
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_pulse = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (sw[0]) begin
                    w_state_nxt = ST_RUN;
                end else if (r_key_press) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!sw[0]) begin
                    w_state_nxt = ST_HALT;
                end else if (w_tick && w_bp_hit) begin
                    w_state_nxt = ST_BREAK;
                end else if (w_tick) begin
                    w_run_pulse = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = sw[0] ? ST_RUN : ST_HALT;
            end
            ST_BREAK: begin
                // Key press wins over run-disable so the step is never lost.
                if (r_key_press) begin
                    w_state_nxt = ST_STEP;
                end else if (!sw[0]) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    // Pulse is registered: high for the whole STEP cycle, or the cycle after
    // a RUN tick that did not hit the breakpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_en      <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_clk_en      <= (w_state_nxt == ST_STEP) || w_run_pulse;
            r_pulse_count <= r_pulse_count + 32'(r_clk_en);
        end
    end

    assign cpu_clk_en  = r_clk_en;
    assign state_o     = r_state;
    assign pulse_count = r_pulse_count;
    assign LED_clk     = {r_state == ST_BREAK, r_state == ST_HALT, r_state == ST_RUN};

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Testbench for cpu_clk_ctrl: cycle-level reference model feeding a pulse
// scoreboard, directed scenarios plus a randomized phase.
module tb_cpu_clk_ctrl;

    localparam int DB = 4;
`ifdef CLK_CTRL_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_BRK  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        key1;
    logic [31:0] pc_in;
    logic [31:0] bp_addr;
    logic        cpu_clk_en;
    logic [1:0]  state_o;
    logic [31:0] pulse_count;
    logic [2:0]  LED_clk;

    cpu_clk_ctrl #(.DB_CYCLES(DB), .DIV_WIDTH(26)) dut (
        .clk(clk), .rst(rst), .sw(sw), .key1(key1), .pc_in(pc_in),
        .bp_addr(bp_addr), .cpu_clk_en(cpu_clk_en), .state_o(state_o),
        .pulse_count(pulse_count), .LED_clk(LED_clk)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        logic [1:0] st;
    } pulse_t;

    pulse_t      exp_q[$];
    int          kp_q[$];
    logic [1:0]  m_st = S_HALT;
    logic        m_en = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    int          m_run_start = 0;
    bit          m_live = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rate_of(logic [15:0] s);
        if (s[4]) return 2;
        for (int i = 5; i <= 15; i++) begin
            if (s[i]) return i + 10;
        end
        return 26;
    endfunction

    function automatic logic [2:0] led_of(logic [1:0] s);
        case (s)
            S_HALT:  return 3'b010;
            S_RUN:   return 3'b001;
            S_BRK:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Reference model: evaluated with the inputs present during cycle c,
    // producing the values the DUT should show during cycle c+1.
    always @(posedge clk) begin
        int         c;
        int         k;
        bit         kp;
        bit         tick;
        bit         hit;
        logic [1:0] nx;
        bit         en_n;
        c  = cyc;
        kp = 1'b0;
        while (kp_q.size() > 0 && kp_q[0] < c) void'(kp_q.pop_front());
        if (kp_q.size() > 0 && kp_q[0] == c) begin
            kp = 1'b1;
            void'(kp_q.pop_front());
        end
        if (rst) begin
            m_st   <= S_HALT;
            m_en   <= 1'b0;
            m_cnt  <= 32'd0;
            m_live <= 1'b1;
            kp_q.delete();
        end else if (m_live) begin
            k    = rate_of(sw);
            tick = (m_st == S_RUN) && (((c - m_run_start) % (1 << k)) == (1 << k) - 1);
            hit  = BP_EN && sw[1] && (pc_in == bp_addr);
            nx   = m_st;
            en_n = 1'b0;
            case (m_st)
                S_HALT: if (sw[0]) nx = S_RUN; else if (kp) nx = S_STEP;
                S_RUN: begin
                    if (!sw[0]) nx = S_HALT;
                    else if (tick && hit) nx = S_BRK;
                    else if (tick) en_n = 1'b1;
                end
                S_STEP: nx = sw[0] ? S_RUN : S_HALT;
                default: if (kp) nx = S_STEP; else if (!sw[0]) nx = S_HALT;
            endcase
            if (nx == S_STEP) en_n = 1'b1;
            if (nx == S_RUN && m_st != S_RUN) m_run_start <= c + 1;
            if (en_n) exp_q.push_back('{c + 1, nx});
            m_st  <= nx;
            m_en  <= en_n;
            m_cnt <= m_cnt + (m_en ? 32'd1 : 32'd0);
        end
        cyc <= c + 1;
    end

    // Monitor: per-cycle state/LED/count, and scoreboard pop on every pulse.
    always @(negedge clk) begin
        pulse_t p;
        if (m_live) begin
            check("state", 32'(state_o), 32'(m_st));
            check("led", 32'(LED_clk), 32'(led_of(m_st)));
            check("pulse_count", pulse_count, m_cnt);
            if (cpu_clk_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(exp_q.size()), 32'd1);
                end else begin
                    p = exp_q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(p.at));
                    check("pulse_state", 32'(state_o), 32'(p.st));
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                p = exp_q.pop_front();
                check("missed_pulse_at", 32'(cyc), 32'(p.at - 1));
            end
        end
    end

    // The CPU: PC advances by 4 on every enable pulse.
    always @(negedge clk) begin
        if (cpu_clk_en === 1'b1) pc_in = pc_in + 32'd4;
    end

    task automatic press_key(int h, int l);
        key1 = 1'b1;
        if (h >= DB) kp_q.push_back(cyc + DB + 3);
        repeat (h) @(negedge clk);
        key1 = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic wait_state(logic [1:0] s, int budget, string nm);
        int i;
        i = 0;
        while (state_o !== s && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(nm, 32'(state_o), 32'(s));
    endtask

    initial begin
        int         r;
        logic [31:0] c0;
        logic [31:0] d;
        bit         saw_break;
        rst = 1'b1; key1 = 1'b1; sw = 16'h0; pc_in = 32'd0; bp_addr = 32'hFFFF_FFF0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_count", pulse_count, 32'd0);
        check("rst_led", 32'(LED_clk), 32'b010);
        check("rst_en", 32'(cpu_clk_en), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("held_key_no_pulse", pulse_count, 32'd0);
        key1 = 1'b0;
        repeat (DB + 6) @(negedge clk);

        press_key(3, DB + 6);
        check("glitch_no_pulse", pulse_count, 32'd0);

        r = cyc;
        key1 = 1'b1;
        kp_q.push_back(r + DB + 3);
        repeat (8) @(negedge clk);
        check("step_state", 32'(state_o), 32'(S_STEP));
        check("step_en", 32'(cpu_clk_en), 32'd1);
        @(negedge clk);
        check("step_then_halt", 32'(state_o), 32'(S_HALT));
        check("step_count", pulse_count, 32'd1);
        @(negedge clk);
        key1 = 1'b0;
        repeat (DB + 6) @(negedge clk);

        c0 = pulse_count;
        sw = 16'h0011;
        repeat (41) @(negedge clk);
        d = pulse_count - c0;
        check("run_rate_40cyc", 32'(d >= 32'd9 && d <= 32'd11), 32'd1);
        sw = 16'h0010;
        @(negedge clk);
        check("run_stop_halt", 32'(state_o), 32'(S_HALT));
        c0 = pulse_count;
        repeat (10) @(negedge clk);
        check("halt_no_pulses", pulse_count, c0);

        sw = 16'h0;
        repeat (3) @(negedge clk);
        pc_in = 32'd0;
        bp_addr = 32'h10;
        c0 = pulse_count;
        sw = 16'h0013;
        for (int i = 0; i < 80 && state_o !== S_BRK; i++) @(negedge clk);
        #2;
        check("bp_state", 32'(state_o), BP_EN ? 32'(S_BRK) : 32'(S_RUN));
        check("bp_led", 32'(LED_clk), BP_EN ? 32'b100 : 32'b001);
        check("bp_passed_0x10", 32'(pc_in > 32'h10), BP_EN ? 32'd0 : 32'd1);
        check("bp_pulses_vs_pc", pulse_count - c0, pc_in >> 2);
        saw_break = (state_o === S_BRK);
        @(negedge clk);
        if (saw_break) begin
            key1 = 1'b1;
            kp_q.push_back(cyc + DB + 3);
            wait_state(S_STEP, 30, "resume_step");
            @(negedge clk);
            check("resume_run", 32'(state_o), 32'(S_RUN));
            check("resume_pc", pc_in, 32'h14);
            repeat (4) @(negedge clk);
            key1 = 1'b0;
            repeat (DB + 6) @(negedge clk);
        end
        sw = 16'h0;
        repeat (4) @(negedge clk);

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    logic [15:0] v;
                    v = 16'($urandom);
                    if (!v[4]) v[15:4] = 12'h0;
                    sw = v;
                    @(negedge clk);
                end
                1: press_key(int'($urandom_range(DB, DB + 4)), int'($urandom_range(DB + 5, DB + 8)));
                2: press_key(int'($urandom_range(1, DB - 1)), DB + 5);
                3: begin
                    bp_addr = pc_in + 32'(4 * $urandom_range(0, 3));
                    @(negedge clk);
                end
                default: repeat ($urandom_range(1, 12)) @(negedge clk);
            endcase
        end

        sw = 16'h0;
        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        key1 = 1'b1;
        kp_q.push_back(cyc + DB + 3);
        wait_state(S_STEP, 30, "rst_mid_step");
        sw = 16'h0011;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_state", 32'(state_o), 32'(S_HALT));
        check("rst_mid_en", 32'(cpu_clk_en), 32'd0);
        check("rst_mid_count", pulse_count, 32'd0);
        rst = 1'b0;
        sw = 16'h0;
        repeat (3) @(negedge clk);
        key1 = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
